instr_encoder_loader: RTL and testbench

//  Counterpart of the main decoder: assembles RV32I instruction words from field inputs and writes them into instruction memory.
//  - Covers the classes the decoder accepts: I-ALU, R, Store, Load, Branch.
//  - Fields arrive over a valid/ready handshake; each encoded word goes to the next word address.
//  - Used by benches and boot logic to load test programs before releasing the CPU.

---
 rtl/instr_encoder_loader.sv | 159 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: turns RV32I field sets (I-ALU, R, Store, Load, Branch)
// into instruction words and writes them to consecutive IMEM word addresses.
// Optional feature macro: ENCODER_CHECKSUM_EN adds oChecksum, the running XOR
// of every word written in the current session.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic              iFinish,
  input  logic              iValid,
  output logic              oReady,
  input  logic [2:0]        iType,
  input  logic [2:0]        iFunct3,
  input  logic [6:0]        iFunct7,
  input  logic [4:0]        iRd,
  input  logic [4:0]        iRs1,
  input  logic [4:0]        iRs2,
  input  logic [11:0]       iImm,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [31:0]       oMemWdata,
  output logic [ADDR_W:0]   oCount,
  output logic              oErr,
  output logic              oFull,
  output logic              oDone
`ifdef ENCODER_CHECKSUM_EN
  ,
  output logic [31:0]       oChecksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_FULL
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   count;
  logic              err;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       enc_word;
  logic              type_legal;

  // Build the instruction word for the presented field set; flag unknown classes
  always_comb begin
    enc_word   = '0;
    type_legal = 1'b1;
    case (iType)
      3'd0: enc_word = {iImm, iRs1, iFunct3, iRd, 7'b0010011};
      3'd1: enc_word = {iFunct7, iRs2, iRs1, iFunct3, iRd, 7'b0110011};
      3'd2: enc_word = {iImm[11:5], iRs2, iRs1, iFunct3, iImm[4:0], 7'b0100011};
      3'd3: enc_word = {iImm, iRs1, iFunct3, iRd, 7'b0000011};
      3'd4: enc_word = {iImm[11], iImm[9:4], iRs2, iRs1, iFunct3,
                        iImm[3:0], iImm[10], 7'b1100011};
      default: type_legal = 1'b0;
    endcase
  end

  // Next-state decode: iStart overrides everything, then handshake, then iFinish
  always_comb begin
    state_next = state;
    if (iStart) begin
      state_next = S_ACCEPT;
    end else begin
      case (state)
        S_ACCEPT: begin
          if (iValid) begin
            if (type_legal) state_next = S_WRITE;
          end else if (iFinish) begin
            state_next = S_IDLE;
          end
        end
        S_WRITE: state_next = (ptr == PTR_LAST) ? S_FULL : S_ACCEPT;
        default: state_next = state;
      endcase
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge iClk) begin
    if (!iRst_n) state <= S_IDLE;
    else         state <= state_next;
  end

  // Session datapath: pointer, word count, sticky error, finish pulse and IMEM bus
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      ptr       <= PTR_BASE;
      count     <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      if (iStart) begin
        ptr   <= PTR_BASE;
        count <= '0;
        err   <= 1'b0;
      end else begin
        case (state)
          S_ACCEPT: begin
            if (iValid) begin
              if (type_legal) begin
                mem_addr  <= ptr;
                mem_wdata <= enc_word;
              end else begin
                err <= 1'b1;
              end
            end else if (iFinish) begin
              done <= 1'b1;
            end
          end
          S_WRITE: begin
            ptr   <= ptr + ADDR_W'(1);
            count <= count + (ADDR_W + 1)'(1);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ENCODER_CHECKSUM_EN
  logic [31:0] checksum;

  // Running XOR of written words, folded in as each write completes
  always_ff @(posedge iClk) begin
    if (!iRst_n)               checksum <= '0;
    else if (iStart)           checksum <= '0;
    else if (state == S_WRITE) checksum <= checksum ^ mem_wdata;
  end

  assign oChecksum = checksum;
`endif

  // Write enable is gated by reset so nothing reaches IMEM while held in reset
  assign oMemWe    = (state == S_WRITE) && iRst_n;
  assign oReady    = (state == S_ACCEPT);
  assign oFull     = (state == S_FULL);
  assign oErr      = err;
  assign oDone     = done;
  assign oCount    = count;
  assign oMemAddr  = mem_addr;
  assign oMemWdata = mem_wdata;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed literal checks followed by random
// traffic compared every cycle against a field-level reference model.
module tb_instr_encoder_loader;

  localparam int AW  = 3;
  localparam int CAP = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          finish;
  logic          valid;
  logic [2:0]    itype;
  logic [2:0]    f3;
  logic [6:0]    f7;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [11:0]   imm;
  logic          ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          err;
  logic          full;
  logic          done;
`ifdef ENCODER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  bit chkEn       = 1'b0;

  // reference model state, expressed as session facts rather than FSM states
  bit          mActive;
  bit          mPending;
  bit          mFull;
  bit          mErr;
  bit          mDone;
  int          mPtr;
  int          mCount;
  logic [31:0] mAddr;
  logic [31:0] mWdata;
  logic [31:0] mSum;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .iClk(clk), .iRst_n(rst_n), .iStart(start), .iFinish(finish),
    .iValid(valid), .oReady(ready), .iType(itype), .iFunct3(f3),
    .iFunct7(f7), .iRd(rd), .iRs1(rs1), .iRs2(rs2), .iImm(imm),
    .oMemWe(mem_we), .oMemAddr(mem_addr), .oMemWdata(mem_wdata),
    .oCount(count), .oErr(err), .oFull(full), .oDone(done)
`ifdef ENCODER_CHECKSUM_EN
    , .oChecksum(checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encode straight from the ISA description; branch takes a byte offset
  function automatic logic [31:0] modelEncode(input int t, input logic [2:0] fn3,
      input logic [6:0] fn7, input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [11:0] im);
    logic [12:0] off;
    off = {im, 1'b0};
    case (t)
      0: return {im, s1, fn3, d, 7'h13};
      1: return {fn7, s2, s1, fn3, d, 7'h33};
      2: return {im[11:5], s2, s1, fn3, im[4:0], 7'h23};
      3: return {im, s1, fn3, d, 7'h03};
      4: return {off[12], off[10:5], s2, s1, fn3, off[4:1], off[11], 7'h63};
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs the DUT just sampled
  task automatic modelStep();
    if (!rst_n) begin
      mActive = 0; mPending = 0; mFull = 0; mErr = 0; mDone = 0;
      mPtr = 0; mCount = 0; mAddr = 0; mWdata = 0; mSum = 0;
      return;
    end
    mDone = 0;
    if (start) begin
      mActive = 1; mPending = 0; mFull = 0; mErr = 0;
      mPtr = 0; mCount = 0; mSum = 0;
    end else if (mPending) begin
      mPending = 0;
      mCount++;
      mSum ^= mWdata;
      if (mPtr == CAP - 1) begin
        mFull = 1; mActive = 0;
      end
      mPtr = (mPtr + 1) % CAP;
    end else if (mActive) begin
      if (valid) begin
        if (int'(itype) <= 4) begin
          mPending = 1;
          mAddr    = mPtr;
          mWdata   = modelEncode(int'(itype), f3, f7, rd, rs1, rs2, imm);
        end else begin
          mErr = 1;
        end
      end else if (finish) begin
        mActive = 0;
        mDone   = 1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input bit st, input bit fin, input bit v,
      input logic [2:0] t, input logic [2:0] fn3, input logic [6:0] fn7,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [11:0] im);
    start = st; finish = fin; valid = v; itype = t; f3 = fn3; f7 = fn7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
    tick();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
  endtask

  // Every cycle, compare all DUT outputs with what the model says they must be
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("cyc_we",    {31'd0, mem_we}, {31'd0, mPending && rst_n});
      checkOutput("cyc_ready", {31'd0, ready},  {31'd0, mActive && !mPending});
      checkOutput("cyc_full",  {31'd0, full},   {31'd0, mFull});
      checkOutput("cyc_err",   {31'd0, err},    {31'd0, mErr});
      checkOutput("cyc_done",  {31'd0, done},   {31'd0, mDone});
      checkOutput("cyc_count", 32'(count),      32'(mCount));
      checkOutput("cyc_addr",  32'(mem_addr),   mAddr);
      checkOutput("cyc_wdata", mem_wdata,       mWdata);
`ifdef ENCODER_CHECKSUM_EN
      checkOutput("cyc_sum",   checksum,        mSum);
`endif
    end
  end

  initial begin
    rst_n = 0; start = 0; finish = 0; valid = 0; itype = 0; f3 = 0; f7 = 0;
    rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    tick();
    tick();
    chkEn = 1'b1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_ready", {31'd0, ready}, 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1;

    // addi x1,x0,5
    applyStimulus(1, 0, 0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    applyStimulus(0, 0, 1, 3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 12'd5);
    checkOutput("addi_we", {31'd0, mem_we}, 32'd1);
    checkOutput("addi_addr", 32'(mem_addr), 32'd0);
    checkOutput("addi_word", mem_wdata, 32'h00500093);
    idleCycle();
    checkOutput("addi_count", 32'(count), 32'd1);

    // add x3,x1,x2 then sw x3,8(x0) in a fresh session
    applyStimulus(1, 0, 0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    applyStimulus(0, 0, 1, 3'd1, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 12'd0);
    checkOutput("add_word", mem_wdata, 32'h002081B3);
    checkOutput("add_addr", 32'(mem_addr), 32'd0);
    idleCycle();
    applyStimulus(0, 0, 1, 3'd2, 3'd2, 7'd0, 5'd0, 5'd0, 5'd3, 12'd8);
    checkOutput("sw_word", mem_wdata, 32'h00302423);
    checkOutput("sw_addr", 32'(mem_addr), 32'd1);
    idleCycle();

    // lw x5,4(x1) and beq x1,x2,+8
    applyStimulus(0, 0, 1, 3'd3, 3'd2, 7'd0, 5'd5, 5'd1, 5'd0, 12'd4);
    checkOutput("lw_word", mem_wdata, 32'h0040A283);
    idleCycle();
    applyStimulus(0, 0, 1, 3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 12'd4);
    checkOutput("beq_word", mem_wdata, 32'h00208463);
    idleCycle();

    // illegal type
    applyStimulus(0, 0, 1, 3'd5, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 12'd1);
    checkOutput("ill_we", {31'd0, mem_we}, 32'd0);
    checkOutput("ill_err", {31'd0, err}, 32'd1);
    checkOutput("ill_ready", {31'd0, ready}, 32'd1);
    checkOutput("ill_count", 32'(count), 32'd4);

    // finish pulse
    applyStimulus(0, 1, 0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    checkOutput("fin_done", {31'd0, done}, 32'd1);
    checkOutput("fin_ready", {31'd0, ready}, 32'd0);
    idleCycle();
    checkOutput("fin_done_clr", {31'd0, done}, 32'd0);

    // fill the whole region
    applyStimulus(1, 0, 0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    for (int i = 0; i < CAP; i++) begin
      applyStimulus(0, 0, 1, 3'd0, 3'd0, 7'd0, 5'(i), 5'd0, 5'd0, 12'(i));
      idleCycle();
    end
    checkOutput("full_flag", {31'd0, full}, 32'd1);
    checkOutput("full_ready", {31'd0, ready}, 32'd0);
    checkOutput("full_count", 32'(count), 32'(CAP));
    applyStimulus(0, 0, 1, 3'd0, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 12'd9);
    checkOutput("full_ignore_we", {31'd0, mem_we}, 32'd0);
    checkOutput("full_ignore_count", 32'(count), 32'(CAP));
    applyStimulus(1, 0, 0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    checkOutput("restart_full", {31'd0, full}, 32'd0);
    applyStimulus(0, 0, 1, 3'd0, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 12'd3);
    checkOutput("restart_addr", 32'(mem_addr), 32'd0);
    checkOutput("restart_we", {31'd0, mem_we}, 32'd1);

    // reset asserted during a write cycle
    rst_n = 0;
    #1;
    checkOutput("rstw_we", {31'd0, mem_we}, 32'd0);
    tick();
    checkOutput("rstw_count", 32'(count), 32'd0);
    checkOutput("rstw_wdata", mem_wdata, 32'd0);
    checkOutput("rstw_ready", {31'd0, ready}, 32'd0);
    rst_n = 1;

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      rst_n  = ($urandom_range(0, 199) != 0);
      start  = ($urandom_range(0, 39) == 0);
      finish = ($urandom_range(0, 24) == 0);
      valid  = ($urandom_range(0, 1) == 1);
      itype  = 3'($urandom_range(0, 7));
      f3     = 3'($urandom);
      f7     = 7'($urandom);
      rd     = 5'($urandom);
      rs1    = 5'($urandom);
      rs2    = 5'($urandom);
      imm    = 12'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
